// File: rtl/ahb3lite_byte_master.sv
`default_nettype none
//============================================================================
// Module   : ahb3lite_byte_master
// Function : Byte-stream command interpreter driving single AHB3-lite
//            transfers. Commands arrive on RX (opcode, 4 address bytes,
//            optional 4 write-data bytes); responses leave on TX (read data
//            bytes LSB first, then a status byte).
// Options  : define AHB3LITE_BYTE_MASTER_TIMEOUT_EN to abort data phases
//            that wait TIMEOUT cycles (status 0x02, DRAIN state).
// Revision : 1.0 - initial release
//============================================================================
module ahb3lite_byte_master #(
   parameter int TIMEOUT = 255
) (
   input  logic        CLK,
   input  logic        RESETn,
   input  logic [7:0]  RX_DATA,
   input  logic        RX_VALID,
   output logic        RX_READY,
   output logic [7:0]  TX_DATA,
   output logic        TX_VALID,
   input  logic        TX_READY,
   output logic [31:0] HADDR,
   output logic [31:0] HWDATA,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [2:0]  HBURST,
   output logic [3:0]  HPROT,
   output logic [1:0]  HTRANS,
   output logic        HMASTLOCK,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic        HRESP,
   output logic        BUSY
);

   localparam logic [1:0]  TRANS_IDLE   = 2'b00;
   localparam logic [1:0]  TRANS_NONSEQ = 2'b10;
   localparam logic [15:0] TO_LIMIT     = TIMEOUT[15:0];

   typedef enum logic [2:0] {
      ST_CMD    = 3'd0,
      ST_ADDR   = 3'd1,
      ST_WDATA  = 3'd2,
      ST_APHASE = 3'd3,
      ST_DPHASE = 3'd4,
`ifdef AHB3LITE_BYTE_MASTER_TIMEOUT_EN
      ST_DRAIN  = 3'd5,
`endif
      ST_RESP   = 3'd6
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic        op_write;
   logic [1:0]  op_size;
   logic        op_invalid;
   logic [1:0]  byte_cnt;
   logic [31:0] addr_buf;
   logic [31:0] data_buf;
   logic [31:0] rdata;
   logic [7:0]  status;
   logic [2:0]  tx_idx;

   logic        rx_fire;
   logic        tx_fire;
   logic        last_byte;
   logic        launch;
   logic [31:0] addr_full;
   logic [31:0] data_full;
   logic [31:0] launch_addr;

`ifdef AHB3LITE_BYTE_MASTER_TIMEOUT_EN
   logic [15:0] to_cnt;
   logic        to_hit;
   assign to_hit = (to_cnt + 16'd1) == TO_LIMIT;
`else
   // No abort path in this build; the limit is intentionally left unused.
   logic        unused_timeout;
   assign unused_timeout = ^TO_LIMIT;
`endif

   assign rx_fire    = RX_VALID & RX_READY;
   assign tx_fire    = TX_VALID & TX_READY;
   assign last_byte  = rx_fire & (byte_cnt == 2'd3);
   assign op_invalid = (op_size == 2'd3);
   assign addr_full  = {RX_DATA, addr_buf[31:8]};
   assign data_full  = {RX_DATA, data_buf[31:8]};

   // The command is complete on the last address byte of a read or the
   // last data byte of a write.
   assign launch      = ((state == ST_ADDR) & last_byte & ~op_write) |
                        ((state == ST_WDATA) & last_byte);
   assign launch_addr = (state == ST_ADDR) ? addr_full : addr_buf;

   assign BUSY      = (state != ST_CMD);
   assign HBURST    = 3'b000;
   assign HPROT     = 4'b0011;
   assign HMASTLOCK = 1'b0;

   // Response byte: read data bytes 0..3 LSB first, index 4 is status.
   always_comb begin
      TX_DATA = 8'h00;
      if (state == ST_RESP) begin
         case (tx_idx)
            3'd0:    TX_DATA = rdata[7:0];
            3'd1:    TX_DATA = rdata[15:8];
            3'd2:    TX_DATA = rdata[23:16];
            3'd3:    TX_DATA = rdata[31:24];
            default: TX_DATA = status;
         endcase
      end
   end

   // State register.
   always_ff @(posedge CLK) begin
      if (!RESETn) state <= ST_CMD;
      else         state <= state_nxt;
   end

   // Next-state decode and state-driven handshake/bus outputs.
   always_comb begin
      state_nxt = state;
      RX_READY  = 1'b0;
      TX_VALID  = 1'b0;
      HTRANS    = TRANS_IDLE;
      case (state)
         ST_CMD: begin
            RX_READY = 1'b1;
            if (RX_VALID) state_nxt = ST_ADDR;
         end
         ST_ADDR: begin
            RX_READY = 1'b1;
            if (RX_VALID && byte_cnt == 2'd3) begin
               if (op_write)        state_nxt = ST_WDATA;
               else if (op_invalid) state_nxt = ST_RESP;
               else                 state_nxt = ST_APHASE;
            end
         end
         ST_WDATA: begin
            RX_READY = 1'b1;
            if (RX_VALID && byte_cnt == 2'd3)
               state_nxt = op_invalid ? ST_RESP : ST_APHASE;
         end
         ST_APHASE: begin
            HTRANS = TRANS_NONSEQ;
            if (HREADY) state_nxt = ST_DPHASE;
         end
         ST_DPHASE: begin
            if (HREADY) state_nxt = ST_RESP;
`ifdef AHB3LITE_BYTE_MASTER_TIMEOUT_EN
            else if (to_hit) state_nxt = ST_DRAIN;
`endif
         end
`ifdef AHB3LITE_BYTE_MASTER_TIMEOUT_EN
         ST_DRAIN: begin
            if (HREADY) state_nxt = ST_RESP;
         end
`endif
         ST_RESP: begin
            TX_VALID = 1'b1;
            if (TX_READY && tx_idx == 3'd4) state_nxt = ST_CMD;
         end
         default: state_nxt = ST_CMD;
      endcase
   end

   // Command assembly, bus address/data registers and response capture.
   always_ff @(posedge CLK) begin
      if (!RESETn) begin
         op_write <= 1'b0;
         op_size  <= 2'd0;
         byte_cnt <= 2'd0;
         addr_buf <= 32'h0;
         data_buf <= 32'h0;
         rdata    <= 32'h0;
         status   <= 8'h00;
         tx_idx   <= 3'd0;
         HADDR    <= 32'h0;
         HWDATA   <= 32'h0;
         HWRITE   <= 1'b0;
         HSIZE    <= 3'd0;
`ifdef AHB3LITE_BYTE_MASTER_TIMEOUT_EN
         to_cnt   <= 16'd0;
`endif
      end else begin
         if (state == ST_CMD && rx_fire) begin
            op_write <= RX_DATA[7];
            op_size  <= RX_DATA[1:0];
            byte_cnt <= 2'd0;
         end
         if (state == ST_ADDR && rx_fire) begin
            addr_buf <= addr_full;
            byte_cnt <= byte_cnt + 2'd1;
         end
         if (state == ST_WDATA && rx_fire) begin
            data_buf <= data_full;
            byte_cnt <= byte_cnt + 2'd1;
         end
         // Bus-visible fields change only when a new transfer is issued,
         // so they hold their last values while idle.
         if (launch) begin
            if (op_invalid) begin
               status <= 8'h03;
               tx_idx <= 3'd4;
            end else begin
               HADDR  <= launch_addr;
               HWRITE <= op_write;
               HSIZE  <= {1'b0, op_size};
               if (op_write) HWDATA <= data_full;
               tx_idx <= op_write ? 3'd4 : 3'd0;
            end
         end
         if (state == ST_DPHASE) begin
            if (HREADY) begin
               status <= HRESP ? 8'h01 : 8'h00;
               rdata  <= HRESP ? 32'h0 : HRDATA;
            end
`ifdef AHB3LITE_BYTE_MASTER_TIMEOUT_EN
            else begin
               to_cnt <= to_cnt + 16'd1;
               if (to_hit) begin
                  status <= 8'h02;
                  rdata  <= 32'h0;
               end
            end
`endif
         end
`ifdef AHB3LITE_BYTE_MASTER_TIMEOUT_EN
         if (state == ST_APHASE && HREADY) to_cnt <= 16'd0;
`endif
         if (state == ST_RESP && tx_fire) tx_idx <= tx_idx + 3'd1;
      end
   end

endmodule
`default_nettype wire
